// File: rtl/wait_state_ram_pkg.sv
// Shared constants for the wait-state RAM block.
//   DEFAULT_MADDR_WIDTH / DEFAULT_MDATA_WIDTH : default parameter widths
//   WAIT_COUNT_WIDTH                          : width of the wait-state counter (0..15)
//   state_t                                   : controller FSM encoding (IDLE, BUSY, DONE)
package wait_state_ram_pkg;

    localparam int DEFAULT_MADDR_WIDTH = 10;
    localparam int DEFAULT_MDATA_WIDTH = 8;
    localparam int WAIT_COUNT_WIDTH    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wait_state_ram_ram_array.sv
// Single-port storage array with synchronous write and synchronous read.
//   clock : write and read both happen on posedge
//   reset : clears only the read-data register; the array itself is never
//           reset so it maps onto block RAM
//   we    : write wdata to mem[addr]
//   re    : load rdata from mem[addr]; rdata holds otherwise
//   addr  : word address (already reduced modulo DEPTH)
//   wdata : write data
//   rdata : registered read data
module ram_array #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/wait_state_ram.sv
// Wait-state RAM: a single-port memory that answers each request after a
// programmable number of wait states.
//   reset            : asynchronous, active-high
//   clock            : all state changes on posedge
//   mem_read_enable  : read request level, held until mem_read_ready seen
//   mem_write_enable : write request level, held until mem_write_ready seen
//   mem_write_ready  : write done, held while mem_write_enable stays 1
//   mem_read_ready   : read data valid, held while mem_read_enable stays 1
//   mem_addr         : word address, low log2(DEPTH) bits used
//   mem_read_data    : registered read data, held until the next read executes
//   mem_write_data   : write data
//   debug_state      : current controller state
//
// Handshake: an initiator raises one enable (only a clean logic 1 counts) and
// holds it with address/data. The request is captured on the accepting edge E,
// executes on edge E+WAIT_CYCLES+1 and the matching ready rises after that
// edge. Ready stays high until the initiator drops its enable; ready falls on
// that edge and the controller spends at least one cycle in IDLE before taking
// the next request. Dropping the enable before ready aborts the operation.
// Write wins when both enables are raised together.
module wait_state_ram
    import wait_state_ram_pkg::*;
#(
    parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   reset,
    input  logic                   clock,
    input  logic                   mem_read_enable,
    input  logic                   mem_write_enable,
    output logic                   mem_write_ready,
    output logic                   mem_read_ready,
    input  logic [MADDR_WIDTH-1:0] mem_addr,
    output logic [MDATA_WIDTH-1:0] mem_read_data,
    input  logic [MDATA_WIDTH-1:0] mem_write_data,
    output state_t                 debug_state
);

    localparam int AW = $clog2(DEPTH);

    state_t                        state_q;
    state_t                        state_d;
    logic                          op_write_q;
    logic [AW-1:0]                 addr_q;
    logic [MDATA_WIDTH-1:0]        wdata_q;
    logic [WAIT_COUNT_WIDTH-1:0]   count_q;

    logic wr_req;
    logic rd_req;
    logic op_en;
    logic accept;
    logic execute;
    logic ram_we;
    logic ram_re;

    // X or Z on an enable must not start or sustain an operation.
    assign wr_req = (mem_write_enable === 1'b1);
    assign rd_req = (mem_read_enable === 1'b1);
    assign op_en  = op_write_q ? wr_req : rd_req;

    generate
        if (MADDR_WIDTH > AW) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^mem_addr[MADDR_WIDTH-1:AW];
        end
    endgenerate

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, plus the accept/execute strobes that drive the datapath
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        execute = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_req || rd_req) begin
                    state_d = BUSY;
                    accept  = 1'b1;
                end
            end
            BUSY: begin
                if (!op_en) begin
                    state_d = IDLE;
                end else if (count_q == '0) begin
                    state_d = DONE;
                    execute = 1'b1;
                end
            end
            DONE: begin
                if (!op_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ready is a pure function of the registered state, so reset
    // clears it immediately and only one ready can ever be high.
    always_comb begin
        mem_write_ready = (state_q == DONE) && op_write_q;
        mem_read_ready  = (state_q == DONE) && !op_write_q;
        ram_we          = execute && op_write_q;
        ram_re          = execute && !op_write_q;
        debug_state     = state_q;
    end

    // Request capture and wait counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            count_q    <= '0;
        end else if (accept) begin
            op_write_q <= wr_req;
            addr_q     <= mem_addr[AW-1:0];
            wdata_q    <= mem_write_data;
            count_q    <= WAIT_COUNT_WIDTH'(WAIT_CYCLES);
        end else if (state_q == BUSY && count_q != '0) begin
            count_q    <= count_q - 1'b1;
        end
    end

    ram_array #(
        .AW    (AW),
        .DW    (MDATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (mem_read_data)
    );

endmodule

// File: tb/tb_wait_state_ram.sv
module tb_wait_state_ram;
    import wait_state_ram_pkg::*;

    localparam int AWID  = 10;
    localparam int DWID  = 8;
    localparam int DEPTH = 256;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // DUT A: WAIT_CYCLES = 2
    logic            a_rd_en = 1'b0;
    logic            a_wr_en = 1'b0;
    logic            a_wr_ready;
    logic            a_rd_ready;
    logic [AWID-1:0] a_addr  = '0;
    logic [DWID-1:0] a_rdata;
    logic [DWID-1:0] a_wdata = '0;
    state_t          a_state;

    // DUT B: WAIT_CYCLES = 0
    logic            b_rd_en = 1'b0;
    logic            b_wr_en = 1'b0;
    logic            b_wr_ready;
    logic            b_rd_ready;
    logic [AWID-1:0] b_addr  = '0;
    logic [DWID-1:0] b_rdata;
    logic [DWID-1:0] b_wdata = '0;
    state_t          b_state;

    wait_state_ram #(
        .MADDR_WIDTH (AWID), .MDATA_WIDTH (DWID), .DEPTH (DEPTH), .WAIT_CYCLES (2)
    ) dut_a (
        .reset            (reset),
        .clock            (clock),
        .mem_read_enable  (a_rd_en),
        .mem_write_enable (a_wr_en),
        .mem_write_ready  (a_wr_ready),
        .mem_read_ready   (a_rd_ready),
        .mem_addr         (a_addr),
        .mem_read_data    (a_rdata),
        .mem_write_data   (a_wdata),
        .debug_state      (a_state)
    );

    wait_state_ram #(
        .MADDR_WIDTH (AWID), .MDATA_WIDTH (DWID), .DEPTH (DEPTH), .WAIT_CYCLES (0)
    ) dut_b (
        .reset            (reset),
        .clock            (clock),
        .mem_read_enable  (b_rd_en),
        .mem_write_enable (b_wr_en),
        .mem_write_ready  (b_wr_ready),
        .mem_read_ready   (b_rd_ready),
        .mem_addr         (b_addr),
        .mem_read_data    (b_rdata),
        .mem_write_data   (b_wdata),
        .debug_state      (b_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [DWID-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts edges from the accepting edge (edge 1) until the selected ready
    // is seen high; 0 means it never came within the budget.
    task automatic wait_ready(input bit sel_b, input bit is_wr, output int lat);
        logic rdy;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (sel_b) rdy = is_wr ? b_wr_ready : b_rd_ready;
            else       rdy = is_wr ? a_wr_ready : a_rd_ready;
            if (rdy === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic a_write(input logic [AWID-1:0] ad, input logic [DWID-1:0] d, output int lat);
        a_addr  = ad;
        a_wdata = d;
        a_wr_en = 1'b1;
        wait_ready(1'b0, 1'b1, lat);
        a_wr_en = 1'b0;
        tick();
    endtask

    task automatic a_read(input logic [AWID-1:0] ad, output logic [DWID-1:0] d, output int lat);
        a_addr  = ad;
        a_rd_en = 1'b1;
        wait_ready(1'b0, 1'b0, lat);
        d       = a_rdata;
        a_rd_en = 1'b0;
        tick();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int              lat;
        logic [DWID-1:0] d;
        logic            saw;

        // Reset for two cycles with both enables low
        tick();
        tick();
        check("rst_wr_ready", 32'(a_wr_ready), 32'd0);
        check("rst_rd_ready", 32'(a_rd_ready), 32'd0);
        check("rst_rdata", 32'(a_rdata), 32'd0);
        check("rst_state", 32'(a_state), 32'(IDLE));
        reset = 1'b0;
        tick();

        // Write i*i+5 to addr i, read back; ready exactly at E+3
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(DWID'(i * i + 5));
            a_write(AWID'(i), DWID'(i * i + 5), lat);
            check("wr_latency", 32'(lat), 32'd4);
            check("wr_ready_drop", 32'(a_wr_ready), 32'd0);
            a_read(AWID'(i), d, lat);
            check("rd_latency", 32'(lat), 32'd4);
            check("rd_data", 32'(d), 32'(exp_q.pop_front()));
        end

        // Read data holds after the read handshake ends (last read was 86)
        tick();
        tick();
        check("rd_data_hold", 32'(a_rdata), 32'd86);

        // X on an enable is not a request
        a_wr_en = 1'bx;
        tick();
        tick();
        check("x_enable_state", 32'(a_state), 32'(IDLE));
        a_wr_en = 1'b0;
        tick();

        // Both enables high: write taken, read ignored
        a_addr  = 10'd4;
        a_wdata = 8'hA5;
        a_wr_en = 1'b1;
        a_rd_en = 1'b1;
        saw     = 1'b0;
        lat     = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (a_rd_ready === 1'b1) saw = 1'b1;
            if (a_wr_ready === 1'b1) begin
                lat = n;
                break;
            end
        end
        check("both_wr_latency", 32'(lat), 32'd4);
        check("both_rd_ready_low", 32'(saw), 32'd0);
        a_wr_en = 1'b0;
        a_rd_en = 1'b0;
        tick();
        a_read(10'd4, d, lat);
        check("both_readback", 32'(d), 32'hA5);

        // Write aborted one cycle after acceptance: no ready, no store
        a_addr  = 10'd3;
        a_wdata = 8'h11;
        a_wr_en = 1'b1;
        tick();
        a_wr_en = 1'b0;
        saw     = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (a_wr_ready === 1'b1 || a_rd_ready === 1'b1) saw = 1'b1;
        end
        check("abort_no_ready", 32'(saw), 32'd0);
        check("abort_state", 32'(a_state), 32'(IDLE));
        a_read(10'd3, d, lat);
        check("abort_readback", 32'(d), 32'd14);

        // Address wraps modulo DEPTH
        a_write(AWID'(DEPTH + 2), 8'h77, lat);
        a_read(10'd2, d, lat);
        check("wrap_readback", 32'(d), 32'h77);

        // Reset during BUSY of a write
        a_addr  = 10'd6;
        a_wdata = 8'h33;
        a_wr_en = 1'b1;
        tick();
        tick();
        check("pre_rst_busy", 32'(a_state), 32'(BUSY));
        reset = 1'b1;
        #1;
        check("midrst_wr_ready", 32'(a_wr_ready), 32'd0);
        check("midrst_rd_ready", 32'(a_rd_ready), 32'd0);
        check("midrst_rdata", 32'(a_rdata), 32'd0);
        check("midrst_state", 32'(a_state), 32'(IDLE));
        a_wr_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        a_read(10'd6, d, lat);
        check("midrst_readback", 32'(d), 32'd41);

        // Zero-wait build: ready one cycle after acceptance
        b_addr  = 10'd5;
        b_wdata = 8'h5A;
        b_wr_en = 1'b1;
        wait_ready(1'b1, 1'b1, lat);
        check("w0_wr_latency", 32'(lat), 32'd2);
        b_wr_en = 1'b0;
        tick();
        b_rd_en = 1'b1;
        wait_ready(1'b1, 1'b0, lat);
        check("w0_rd_latency", 32'(lat), 32'd2);
        check("w0_rd_data", 32'(b_rdata), 32'h5A);
        b_rd_en = 1'b0;
        tick();
        check("w0_ready_drop", 32'(b_rd_ready), 32'd0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
